uart_tx_prog: RTL and testbench
===============================

Name: uart_tx_prog

Overview:
UART transmitter for the ICCM programming path. It is the transmit-side counterpart of the programming UART receiver and sends status and acknowledge bytes from the ICCM programming controller back to the host loader. Bytes enter through a valid/ready handshake into a small FIFO and are serialised LSB-first as 8N1 frames at a runtime-configurable bit period.

Parameters:
FIFO_DEPTH, 4, byte FIFO entries; power of two, minimum 2.
CPB_W, 16, width of the clocks-per-bit input.

Ports:
clk_i  input  1  system clock.
rst_i  input  1  reset, synchronous to clk_i, active-high.
clks_per_bit_i  input  CPB_W  clk_i cycles per UART bit; 938 in the SoC.
tx_valid_i  input  1  byte-push request.
tx_byte_i  input  8  byte to send.
tx_ready_o  output  1  FIFO can accept a byte.
tx_o  output  1  serial line; idle high.
tx_busy_o  output  1  a frame is in progress or the FIFO is non-empty.
tx_done_o  output  1  one-cycle pulse at the end of each frame.
fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_i high at a clk_i edge): tx_o=1, tx_ready_o=1, tx_busy_o=0, tx_done_o=0, fifo_level_o=0. The FIFO is emptied and the FSM goes to IDLE.
- Reset mid-frame aborts the frame. tx_o is high from the next edge, and all queued bytes are discarded.
- Push: a byte is accepted on an edge where tx_valid_i && tx_ready_o.
- tx_ready_o = (fifo_level_o != FIFO_DEPTH). It depends only on the registered level.
- When full, a push is refused even if a pop occurs in the same cycle.
- A push and a pop in the same cycle leave the level unchanged.
- Bit period: N = clks_per_bit_i, latched when a byte is popped. N=0 is treated as 1. Changing clks_per_bit_i mid-frame has no effect until the next frame.
- A bit counter runs from 0 to N-1. The last cycle of a bit is when the counter equals N-1.
- FSM states: IDLE, START, DATA, STOP. tx_o is registered.
- IDLE:
  - tx_o=1.
  - If the FIFO is non-empty, pop the head into the shift register, latch N, and go to START.
  - tx_o falls on the edge after the pop cycle.
- START: tx_o=0 for N cycles, then go to DATA with bit index 0.
- DATA:
  - tx_o = shift[idx] for N cycles per bit, LSB first.
  - After idx 7 completes, go to STOP.
  - The 3-bit index wraps only at the frame end.
- STOP:
  - tx_o=1 for N cycles.
  - On the last STOP cycle, tx_done_o=1 for exactly that cycle.
  - If the FIFO is non-empty on that cycle, pop and go directly to START, giving back-to-back frames with no idle gap. Otherwise go to IDLE.
- Frame length is 10*N cycles. Start-bit low to the next start-bit low in streaming is exactly 10*N.
- tx_busy_o = (state != IDLE) || (fifo_level_o != 0).

Optional Feature:
UART_TX_PROG_PARITY_EN:
- When defined, a PARITY state is inserted between DATA and STOP.
- It drives tx_o = ^byte (even parity) for N cycles, giving 8E1 frames of 11*N cycles.
- When not defined, the PARITY state and its logic are absent and frames are 8N1 (10*N).

Test Plan:
- Reset, then clks_per_bit_i=4, push 0xA5 -> tx_o low for 4 cycles, then the bit sequence 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4. tx_done_o pulses once, on the 40th cycle after tx_o falls.
- Push 0x00,0xFF,0x55 back-to-back with N=4 -> each start bit falls exactly 40 cycles after the previous one. tx_done_o fires 3 times, and tx_busy_o drops the cycle after the third STOP ends.
- Hold tx_valid_i high with FIFO_DEPTH=4 while transmitting -> tx_ready_o goes low when the level reaches 4. The level never exceeds 4, and no byte is lost or duplicated (the line decodes the same sequence that was pushed).
- Assert rst_i for 1 cycle during DATA bit 3 of 0x3C with 2 bytes queued -> tx_o=1 from the next edge, the level reads 0, and no further frames appear.
- clks_per_bit_i=0, push 0x81 -> the frame is 10 cycles long, 1 cycle per bit. Then change to 8 mid-frame -> the current frame stays at 1 cycle per bit and the next byte uses 80 cycles.
- With UART_TX_PROG_PARITY_EN, N=4, push 0x07 -> the parity bit is 1, sent for 4 cycles before STOP, and the frame is 44 cycles long. Push 0x03 -> the parity bit is 0.

Source files
------------

// File: rtl/uart_tx_prog.sv
// uart_tx_prog: UART transmitter for the ICCM programming path.
// Status and acknowledge bytes are queued through a valid/ready push port into
// a small FIFO. They are serialised LSB-first at a bit period, in clk_i
// cycles, that is latched per frame.
// Optional build macro: UART_TX_PROG_PARITY_EN. When defined, an even-parity
// bit is inserted between the data bits and the stop bit, giving 8E1 frames.
// The default build produces 8N1 frames.

module uart_tx_prog #(
  parameter int FIFO_DEPTH = 4,   // power of two, at least 2
  parameter int CPB_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [CPB_W-1:0]              clks_per_bit_i,
  input  logic                          tx_valid_i,
  input  logic [7:0]                    tx_byte_i,
  output logic                          tx_ready_o,
  output logic                          tx_o,
  output logic                          tx_busy_o,
  output logic                          tx_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [CPB_W-1:0] ONE_CPB  = CPB_W'(1);

`ifdef UART_TX_PROG_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push;
  logic             pop;
  logic [7:0]       head;

  // Ready depends only on the registered level, so a same-cycle pop never
  // opens a slot for a push while the FIFO is full.
  assign tx_ready_o   = (level_q != FULL_LVL);
  assign push         = tx_valid_i && tx_ready_o;
  assign head         = mem_q[rd_ptr_q];
  assign fifo_level_o = level_q;

  // Pointer and occupancy bookkeeping for pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage write; the contents need no reset because the level gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_byte_i;
    end
  end

  // FIFO pointer and level registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame serialiser
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CPB_W-1:0] cnt_q, cnt_d;     // cycle within the current bit
  logic [CPB_W-1:0] n_q, n_d;         // bit period latched for this frame
  logic [2:0]       idx_q, idx_d;     // data bit index, wraps at frame end
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic [CPB_W-1:0] n_in;
  logic             bit_last;

  // A zero period would never terminate a bit, so it is promoted to one cycle.
  assign n_in     = (clks_per_bit_i == '0) ? ONE_CPB : clks_per_bit_i;
  assign bit_last = (cnt_q == (n_q - ONE_CPB));

  // Next-state logic. The line value is derived from the next state so that
  // tx_o is registered and changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (level_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          n_d     = n_in;
          state_d = START;
        end
      end

      START: begin
        if (bit_last) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + ONE_CPB;
        end
      end

      DATA: begin
        if (bit_last) begin
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PROG_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + ONE_CPB;
        end
      end

`ifdef UART_TX_PROG_PARITY_EN
      PARITY: begin
        if (bit_last) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + ONE_CPB;
        end
      end
`endif

      STOP: begin
        if (bit_last) begin
          cnt_d = '0;
          // Streaming: pop the next byte on the last stop cycle so the next
          // start bit follows with no idle gap.
          if (level_q != '0) begin
            pop     = 1'b1;
            shift_d = head;
            n_d     = n_in;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE_CPB;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[idx_d];
`ifdef UART_TX_PROG_PARITY_EN
      PARITY:  tx_d = ^shift_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // Serialiser registers; reset aborts any frame and forces the line idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= ONE_CPB;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o      = tx_q;
  assign tx_done_o = (state_q == STOP) && bit_last;
  assign tx_busy_o = (state_q != IDLE) || (level_q != '0);

endmodule

// File: tb/tb_uart_tx_prog.sv
// Testbench for uart_tx_prog. A line decoder rebuilds bytes and frame timing
// from tx_o using the expected bit period; the stimulus keeps its own queue of
// the bytes it expects to see on the line.
`timescale 1ns/1ps

module tb_uart_tx_prog;

  localparam int FIFO_DEPTH = 4;
  localparam int CPB_W      = 16;
`ifdef UART_TX_PROG_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CPB_W-1:0] cpb = 16'd4;
  logic             valid = 1'b0;
  logic [7:0]       byte_in = 8'h00;
  logic             ready;
  logic             tx;
  logic             busy;
  logic             done;
  logic [2:0]       level;

  uart_tx_prog #(.FIFO_DEPTH(FIFO_DEPTH), .CPB_W(CPB_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clks_per_bit_i (cpb),
    .tx_valid_i     (valid),
    .tx_byte_i      (byte_in),
    .tx_ready_o     (ready),
    .tx_o           (tx),
    .tx_busy_o      (busy),
    .tx_done_o      (done),
    .fifo_level_o   (level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- line decoder ----------------
  bit         mon_en = 1'b0;
  int         mon_n  = 4;
  bit         in_frame = 1'b0;
  int         cur_start = 0;
  logic [7:0] rx_data  [$];
  int         rx_start [$];
  bit         rx_ok    [$];
  bit         rx_par   [$];

  int         dn, ds;
  logic [7:0] dd;
  logic       dpar, dfirst;
  bit         dok, dab;

  always begin
    @(negedge clk);
    if (mon_en && tx === 1'b0) begin
      dn = mon_n; ds = cyc; dok = 1'b1; dab = 1'b0;
      dd = 8'h00; dpar = 1'b0; dfirst = 1'b0;
      cur_start = ds; in_frame = 1'b1;
      for (int b = 0; b < NBITS; b++) begin
        for (int k = 0; k < dn; k++) begin
          if (b != 0 || k != 0) @(negedge clk);
          if (!mon_en) begin dab = 1'b1; break; end
          if (k == 0) dfirst = tx;
          else if (tx !== dfirst) dok = 1'b0;
          if (done !== ((b == NBITS - 1) && (k == dn - 1))) dok = 1'b0;
        end
        if (dab) break;
        if (b == 0) begin
          if (dfirst !== 1'b0) dok = 1'b0;
        end else if (b <= 8) begin
          dd[b-1] = dfirst;
        end else if (b == NBITS - 1) begin
          if (dfirst !== 1'b1) dok = 1'b0;
        end else begin
          dpar = dfirst;
        end
      end
      in_frame = 1'b0;
      if (!dab) begin
        rx_data.push_back(dd);
        rx_start.push_back(ds);
        rx_ok.push_back(dok);
        rx_par.push_back(dpar);
      end
    end
  end

  // ---------------- done / busy observers ----------------
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  int   last_busy_fall = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
    busy_prev <= busy;
    if (busy_prev === 1'b1 && busy === 1'b0) last_busy_fall <= cyc;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left on a negedge; one cycle per accepted byte.
  task automatic push(input logic [7:0] b);
    int g;
    g = 0;
    valid = 1'b1;
    byte_in = b;
    while (ready !== 1'b1 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("push_timeout", 32'(g < 2000), 1);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((busy !== 1'b0 || in_frame) && g < 5000);
    check("idle_timeout", 32'(g < 5000), 1);
    @(negedge clk);
  endtask

  task automatic wait_frame();
    int g;
    g = 0;
    while (!in_frame && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("frame_timeout", 32'(g < 2000), 1);
  endtask

  logic [7:0] b2b_tab [3] = '{8'h00, 8'hFF, 8'h55};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base, dbase, s, lows, g, bad, n, idx, mism;
    bit saw_full;
    logic [7:0] rnd [12];
    logic [7:0] exp_q [$];

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_level", level, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Single 0xA5 frame at N=4.
    cpb = 16'd4; mon_n = 4;
    base = rx_data.size(); dbase = done_cnt;
    push(8'hA5);
    wait_idle();
    check("a5_frames", rx_data.size() - base, 1);
    check("a5_data", rx_data[base], 8'hA5);
    check("a5_shape", rx_ok[base], 1);
    check("a5_done_cnt", done_cnt - dbase, 1);
    check("a5_done_pos", last_done_cyc - rx_start[base], 10 * 4 - 1);
    $display("txn a5: data=%02h start=%0d", rx_data[base], rx_start[base]);

    // Back-to-back frames.
    base = rx_data.size(); dbase = done_cnt;
    for (int i = 0; i < 3; i++) push(b2b_tab[i]);
    wait_idle();
    check("b2b_frames", rx_data.size() - base, 3);
    for (int i = 0; i < 3; i++) begin
      check("b2b_data", rx_data[base+i], b2b_tab[i]);
      check("b2b_shape", rx_ok[base+i], 1);
      $display("txn b2b: data=%02h start=%0d", rx_data[base+i], rx_start[base+i]);
    end
    check("b2b_gap1", rx_start[base+1] - rx_start[base], 40);
    check("b2b_gap2", rx_start[base+2] - rx_start[base+1], 40);
    check("b2b_done_cnt", done_cnt - dbase, 3);
    check("b2b_busy_drop", last_busy_fall, last_done_cyc + 1);

    // Random bytes with valid held high; FIFO fills and must not lose bytes.
    n = $urandom_range(1, 3);
    cpb = CPB_W'(n); mon_n = n;
    for (int i = 0; i < 12; i++) rnd[i] = 8'($urandom_range(0, 255));
    exp_q.delete();
    base = rx_data.size();
    idx = 0; g = 0; bad = 0; saw_full = 1'b0;
    while (idx < 12 && g < 3000) begin
      valid = 1'b1;
      byte_in = rnd[idx];
      if (int'(level) > FIFO_DEPTH) bad++;
      if (ready !== (int'(level) != FIFO_DEPTH)) bad++;
      if (ready !== 1'b1) saw_full = 1'b1;
      if (ready === 1'b1) begin
        exp_q.push_back(rnd[idx]);
        idx++;
      end
      @(negedge clk);
      g++;
    end
    valid = 1'b0;
    check("hold_all_pushed", idx, 12);
    check("hold_level_rule", bad, 0);
    check("hold_saw_full", saw_full, 1);
    wait_idle();
    check("hold_frames", rx_data.size() - base, exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rx_data[base+i] !== exp_q[i] || rx_ok[base+i] !== 1'b1) mism++;
`ifdef UART_TX_PROG_PARITY_EN
      if (rx_par[base+i] !== 1'($countones(exp_q[i]) % 2)) mism++;
`endif
      $display("txn hold: n=%0d exp=%02h got=%02h ok=%0d", n, exp_q[i], rx_data[base+i], rx_ok[base+i]);
    end
    check("hold_sequence", mism, 0);
    check("hold_level_end", level, 0);

    // Reset during data bit 3 of 0x3C with two bytes queued.
    cpb = 16'd4; mon_n = 4;
    base = rx_data.size();
    push(8'h3C); push(8'h11); push(8'h22);
    wait_frame();
    s = cur_start;
    g = 0;
    while (cyc != s + 17 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("rst_mid_reach", 32'(g < 200), 1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstm_tx", tx, 1);
    check("rstm_level", level, 0);
    check("rstm_ready", ready, 1);
    check("rstm_busy", busy, 0);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("rstm_quiet", lows, 0);
    check("rstm_no_frames", rx_data.size() - base, 0);
    $display("txn rst_mid: start=%0d lows_after=%0d", s, lows);
    mon_en = 1'b1;

    // N=0 behaves as 1; a mid-frame period change applies to the next frame.
    cpb = 16'd0; mon_n = 1;
    base = rx_data.size(); dbase = done_cnt;
    push(8'h81);
    wait_frame();
    cpb = 16'd8; mon_n = 8;
    push(8'h42);
    wait_idle();
    check("n0_frames", rx_data.size() - base, 2);
    check("n0_data0", rx_data[base], 8'h81);
    check("n0_shape0", rx_ok[base], 1);
    check("n0_data1", rx_data[base+1], 8'h42);
    check("n0_shape1", rx_ok[base+1], 1);
    check("n0_gap", rx_start[base+1] - rx_start[base], NBITS);
    check("n8_done_pos", last_done_cyc - rx_start[base+1], NBITS * 8 - 1);
    check("n0_done_cnt", done_cnt - dbase, 2);
    $display("txn n0: %02h then %02h gap=%0d", rx_data[base], rx_data[base+1],
             rx_start[base+1] - rx_start[base]);

`ifdef UART_TX_PROG_PARITY_EN
    // Even parity: 0x07 has three ones, 0x03 has two.
    cpb = 16'd4; mon_n = 4;
    base = rx_data.size();
    push(8'h07); push(8'h03);
    wait_idle();
    check("par_frames", rx_data.size() - base, 2);
    check("par_data0", rx_data[base], 8'h07);
    check("par_bit0", rx_par[base], 1);
    check("par_data1", rx_data[base+1], 8'h03);
    check("par_bit1", rx_par[base+1], 0);
    check("par_shape", rx_ok[base] & rx_ok[base+1], 1);
    check("par_len", rx_start[base+1] - rx_start[base], 44);
    $display("txn parity: %02h p=%0d, %02h p=%0d", rx_data[base], rx_par[base],
             rx_data[base+1], rx_par[base+1]);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
